// File: rtl/seg_scan_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_ctrl_pkg
// Description : Shared constants for the 7-segment scan controller.
//               Holds the active-low hex segment table, the blank pattern,
//               the digit nibble width and the blink phase type.
//               Segment bit order is {a,b,c,d,e,f,g,dp}, with a as the MSB.
// Revision    : 1.0 - initial release
// ============================================================================
package seg_scan_ctrl_pkg;

  localparam int c_nib_w = 4;
  localparam int c_seg_w = 8;

  localparam logic [c_seg_w-1:0] c_seg_blank = 8'hFF;

  // Active-low patterns for the hex digits 0..F; dp is always off.
  localparam logic [c_seg_w-1:0] c_seg_code [16] = '{
    8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
    8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71
  };

  typedef enum logic {
    PH_OFF = 1'b0,
    PH_ON  = 1'b1
  } blink_phase_t;

  function automatic logic [c_seg_w-1:0] hex_to_seg(input logic [c_nib_w-1:0] nib);
    return c_seg_code[nib];
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg_hex_dec.sv
`default_nettype none
// ============================================================================
// Module      : seg_hex_dec
// Description : Hex nibble to active-low 7-segment decoder (combinational).
//               The output is forced to all-off when en is low.
// Ports       : en   - decoder enable (0 = blank)
//               data - hex nibble to show
//               seg  - active-low segment pattern
// Revision    : 1.0 - initial release
// ============================================================================
module seg_hex_dec
  import seg_scan_ctrl_pkg::*;
(
  input  logic               en,
  input  logic [c_nib_w-1:0] data,
  output logic [c_seg_w-1:0] seg
);

  assign seg = en ? hex_to_seg(data) : c_seg_blank;

endmodule
`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_ctrl
// Description : Time-multiplexed scan controller for an NDIG-digit
//               common-anode 7-segment display. Whole-display updates are
//               taken into a shadow register through a valid/ready handshake.
//               They are copied to the active register only at a frame end,
//               so a frame is never shown half old and half new.
// Ports       : clk, rst_n     - clock, async active-low reset
//               wr_valid/ready - update handshake
//               wr_data        - NDIG nibbles, digit 0 in bits [3:0]
//               wr_mask        - per-digit enable
//               lz_en          - leading-zero suppression (live)
//               blink_en       - whole-display blink (live)
//               an             - active-low one-hot anode select
//               seg            - active-low segment pattern
//               frame_tick     - one-cycle pulse after the last digit slot
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int NDIG         = 8,
  parameter int DIV          = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [c_nib_w*NDIG-1:0] wr_data,
  input  logic [NDIG-1:0]         wr_mask,
  input  logic                    lz_en,
  input  logic                    blink_en,
  output logic [NDIG-1:0]         an,
  output logic [c_seg_w-1:0]      seg,
  output logic                    frame_tick
);

  localparam int c_cnt_w = $clog2(DIV);
  localparam int c_idx_w = $clog2(NDIG);
  localparam int c_blk_w = $clog2(BLINK_FRAMES + 1);

  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DIV - 1);
  localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(NDIG - 1);
  localparam logic [c_blk_w-1:0] c_blk_last = c_blk_w'(BLINK_FRAMES - 1);

  logic [c_cnt_w-1:0]      r_cnt;
  logic [c_idx_w-1:0]      r_idx;
  logic [c_blk_w-1:0]      r_bcnt;
  blink_phase_t            r_phase;
  logic                    r_pending;
  logic [c_nib_w*NDIG-1:0] r_shadow_data;
  logic [NDIG-1:0]         r_shadow_mask;
  logic [c_nib_w*NDIG-1:0] r_act_data;
  logic [NDIG-1:0]         r_act_mask;

  logic                    w_tick;
  logic                    w_frame_end;
  logic                    w_accept;
  logic                    w_blank;
  logic                    w_dec_en;
  logic                    w_zero_acc;
  logic [NDIG-1:0]         w_lz_run;
  logic [c_nib_w-1:0]      w_sel_nib;
  logic                    w_sel_mask;
  logic                    w_sel_lz;
  logic [NDIG-1:0]         w_an_next;
  logic [c_seg_w-1:0]      w_dec_seg;

  assign w_tick      = (r_cnt == c_cnt_last);
  assign w_frame_end = w_tick && (r_idx == c_idx_last);
  assign wr_ready    = !r_pending;
  assign w_accept    = wr_valid && !r_pending;
  assign w_blank     = blink_en && (r_phase == PH_OFF);

  always_comb begin
    w_zero_acc = 1'b1;
    w_lz_run   = '0;
    w_sel_nib  = '0;
    w_sel_mask = 1'b0;
    w_sel_lz   = 1'b0;
    w_an_next  = '1;
    // w_lz_run[i] is set when every active nibble from the top digit down to
    // digit i is zero, i.e. digit i is a leading zero.
    for (int i = NDIG - 1; i >= 0; i--) begin
      w_zero_acc  = w_zero_acc && (r_act_data[c_nib_w*i +: c_nib_w] == '0);
      w_lz_run[i] = w_zero_acc;
    end
    for (int i = 0; i < NDIG; i++) begin
      if (r_idx == c_idx_w'(i)) begin
        w_sel_nib    = r_act_data[c_nib_w*i +: c_nib_w];
        w_sel_mask   = r_act_mask[i];
        w_sel_lz     = w_lz_run[i];
        w_an_next[i] = 1'b0;
      end
    end
  end

  // Digit 0 is exempt from suppression so an all-zero value still shows "0".
  assign w_dec_en = w_sel_mask
                 && !(lz_en && (r_idx != '0) && w_sel_lz)
                 && !w_blank;

  seg_hex_dec u_dec (
    .en   (w_dec_en),
    .data (w_sel_nib),
    .seg  (w_dec_seg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt         <= '0;
      r_idx         <= '0;
      r_bcnt        <= '0;
      r_phase       <= PH_ON;
      r_pending     <= 1'b0;
      r_shadow_data <= '0;
      r_shadow_mask <= '0;
      r_act_data    <= '0;
      r_act_mask    <= '0;
      an            <= '1;
      seg           <= c_seg_blank;
      frame_tick    <= 1'b0;
    end else begin
      r_cnt      <= w_tick ? '0 : r_cnt + 1'b1;
      frame_tick <= w_frame_end;
      an         <= w_an_next;
      seg        <= w_dec_seg;

      if (w_tick) begin
        r_idx <= (r_idx == c_idx_last) ? '0 : r_idx + 1'b1;
      end

      if (w_frame_end) begin
        if (r_bcnt == c_blk_last) begin
          r_bcnt  <= '0;
          r_phase <= (r_phase == PH_ON) ? PH_OFF : PH_ON;
        end else begin
          r_bcnt <= r_bcnt + 1'b1;
        end
        if (r_pending) begin
          r_act_data <= r_shadow_data;
          r_act_mask <= r_shadow_mask;
          r_pending  <= 1'b0;
        end
      end

      // An accept needs pending=0, so it can never collide with the copy
      // above; a write landing on a frame end simply waits one more frame.
      if (w_accept) begin
        r_shadow_data <= wr_data;
        r_shadow_mask <= wr_mask;
        r_pending     <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
